// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - core-wide widths shared by the pipeline stages
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;

endpackage

// File: rtl/id2exe_pkg.sv
// rtl/id2exe_pkg.sv - ID->EXE payload and pipeline-register state types
package id2exe_pkg;
  import core_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  rd_we;
  } id2exe_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } id2exe_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and synchronous reset
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc_en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/id2exe_pipe.sv
// rtl/id2exe_pipe.sv - ID->EXE pipeline register with flush and stall counter; ID2EXE_SKID_EN selects the skid-buffer build
module id2exe_pipe
  import id2exe_pkg::*;
#(
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  id2exe_t                   id_payload_i,
  output logic                      exe_valid_o,
  input  logic                      exe_ready_i,
  output id2exe_t                   exe_payload_o,
  input  logic                      flush_i,
  output logic [PERF_CNT_WIDTH-1:0] stall_cnt_o
);

  id2exe_state_e state;
  id2exe_t       main_q;
  logic          in_xfer;
  logic          out_xfer;

  assign exe_valid_o   = (state != EMPTY);
  assign exe_payload_o = main_q;
  assign in_xfer       = id_valid_i & id_ready_o;
  assign out_xfer      = exe_valid_o & exe_ready_i;

`ifdef ID2EXE_SKID_EN
  id2exe_t skid_q;
  logic    ready_q;

  assign id_ready_o = ready_q;

  // Handshake FSM: main register feeds EXE, skid absorbs the one input taken while EXE stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      ready_q <= 1'b1;
    end else if (flush_i) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q <= id_payload_i;
            state  <= FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_q <= id_payload_i;
          end else if (in_xfer) begin
            state   <= SKID;
            ready_q <= 1'b0;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state   <= FULL;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Skid capture; only consumed after a FULL->SKID move, so unconditional loading in FULL is harmless
  always_ff @(posedge clk) begin
    if (state == FULL && in_xfer) begin
      skid_q <= id_payload_i;
    end
  end
`else
  assign id_ready_o = ~exe_valid_o | exe_ready_i;

  // Single-register pipe: a new input replaces main whenever EXE drains it or it is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
    end else if (flush_i) begin
      state <= EMPTY;
    end else if (in_xfer) begin
      main_q <= id_payload_i;
      state  <= FULL;
    end else if (out_xfer) begin
      state <= EMPTY;
    end
  end
`endif

  sat_counter #(
    .WIDTH(PERF_CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_en(exe_valid_o & ~exe_ready_i),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_id2exe_pipe.sv
// tb/tb_id2exe_pipe.sv - directed scoreboard bench for id2exe_pipe (both ID2EXE_SKID_EN builds)
module tb_id2exe_pipe;
  import id2exe_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic          id_ready;
  id2exe_t       id_payload;
  logic          exe_valid;
  logic          exe_ready;
  id2exe_t       exe_payload;
  logic          flush;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  id2exe_t sb[$];

  always #5 clk = ~clk;

  id2exe_pipe #(
    .PERF_CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid_i   (id_valid),
    .id_ready_o   (id_ready),
    .id_payload_i (id_payload),
    .exe_valid_o  (exe_valid),
    .exe_ready_i  (exe_ready),
    .exe_payload_o(exe_payload),
    .flush_i      (flush),
    .stall_cnt_o  (stall_cnt)
  );

  function automatic id2exe_t mk(input logic [31:0] pc);
    id2exe_t p;
    p.pc       = pc;
    p.rs1_data = pc ^ 32'hA5A5_0001;
    p.rs2_data = pc + 32'h0100_0000;
    p.imm      = ~pc;
    p.rd       = pc[6:2];
    p.alu_op   = pc[5:2];
    p.rd_we    = pc[2];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one cycle: drive just after the rising edge, return at the falling edge for sampling
  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    rst        = r;
    id_valid   = v;
    id_payload = mk(pc);
    exe_ready  = rdy;
    flush      = fl;
    @(negedge clk);
  endtask

  // scoreboard: pop on output transfer, push on accepted input, drop everything on flush/reset
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      sb.delete();
    end else begin
      if (exe_valid && exe_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", {128'd0, exe_payload.pc}, 160'hFFFF_FFFF);
        end else begin
          chk("sb_payload", 160'(exe_payload), 160'(sb.pop_front()));
        end
      end
      if (flush) begin
        sb.delete();
      end else if (id_valid && id_ready) begin
        sb.push_back(id_payload);
      end
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_payload = '0; exe_ready = 1'b0; flush = 1'b0;

    // reset state
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_exe_valid", 160'(exe_valid), 160'd0);
    chk("rst_id_ready", 160'(id_ready), 160'd1);
    chk("rst_payload", 160'(exe_payload), 160'd0);
    chk("rst_cnt", 160'(stall_cnt), 160'd0);

    // streaming at one per cycle
    drive(0, 1, 32'h0, 1, 0);
    chk("strm_ready0", 160'(id_ready), 160'd1);
    chk("strm_valid0", 160'(exe_valid), 160'd0);
    drive(0, 1, 32'h4, 1, 0);
    chk("strm_pc0", 160'(exe_payload.pc), 160'h0);
    chk("strm_ready1", 160'(id_ready), 160'd1);
    drive(0, 1, 32'h8, 1, 0);
    chk("strm_pc4", 160'(exe_payload.pc), 160'h4);
    chk("strm_ready2", 160'(id_ready), 160'd1);
    drive(0, 0, 32'h0, 1, 0);
    chk("strm_pc8", 160'(exe_payload.pc), 160'h8);
    drive(0, 0, 32'h0, 1, 0);
    chk("strm_drained", 160'(exe_valid), 160'd0);
    chk("strm_cnt", 160'(stall_cnt), 160'd0);

    // stall with back-pressure
    drive(0, 1, 32'h10, 1, 0);
`ifdef ID2EXE_SKID_EN
    drive(0, 1, 32'h14, 0, 0);
    chk("skid_pc_c2", 160'(exe_payload.pc), 160'h10);
    chk("skid_take14", 160'(id_ready), 160'd1);
    drive(0, 1, 32'h18, 0, 0);
    chk("skid_ready_drop", 160'(id_ready), 160'd0);
    chk("skid_pc_c3", 160'(exe_payload.pc), 160'h10);
    drive(0, 1, 32'h18, 0, 0);
    chk("skid_ready_held", 160'(id_ready), 160'd0);
    drive(0, 1, 32'h18, 1, 0);
    chk("skid_cnt3", 160'(stall_cnt), 160'd3);
    chk("skid_pc_rel", 160'(exe_payload.pc), 160'h10);
    drive(0, 1, 32'h18, 1, 0);
    chk("skid_pc14", 160'(exe_payload.pc), 160'h14);
    chk("skid_ready_back", 160'(id_ready), 160'd1);
    drive(0, 0, 32'h0, 1, 0);
    chk("skid_pc18", 160'(exe_payload.pc), 160'h18);
`else
    drive(0, 1, 32'h14, 0, 0);
    chk("nsk_ready_comb0", 160'(id_ready), 160'd0);
    chk("nsk_pc_hold", 160'(exe_payload.pc), 160'h10);
    drive(0, 1, 32'h14, 1, 0);
    chk("nsk_ready_comb1", 160'(id_ready), 160'd1);
    chk("nsk_cnt1", 160'(stall_cnt), 160'd1);
    drive(0, 0, 32'h0, 1, 0);
    chk("nsk_pc14", 160'(exe_payload.pc), 160'h14);
`endif
    drive(0, 0, 32'h0, 1, 0);
    chk("stall_drained", 160'(exe_valid), 160'd0);

    // flush with storage full (SKID in the skid build)
    drive(0, 1, 32'h1C, 0, 0);
    drive(0, 1, 32'h24, 0, 0);
    drive(0, 1, 32'h20, 0, 1);
    drive(0, 0, 32'h0, 0, 0);
    chk("fl_valid", 160'(exe_valid), 160'd0);
    chk("fl_ready", 160'(id_ready), 160'd1);
`ifdef ID2EXE_SKID_EN
    chk("fl_cnt_kept", 160'(stall_cnt), 160'd5);
`else
    chk("fl_cnt_kept", 160'(stall_cnt), 160'd3);
`endif
    // flush drops an input offered while id_ready is high
    drive(0, 1, 32'h28, 1, 1);
    drive(0, 0, 32'h0, 1, 0);
    chk("fl_drop_offer", 160'(exe_valid), 160'd0);

    // reset in the middle of a stall
    drive(0, 1, 32'h30, 0, 0);
    drive(0, 1, 32'h34, 0, 0);
    drive(1, 1, 32'h38, 0, 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("mrst_valid", 160'(exe_valid), 160'd0);
    chk("mrst_payload", 160'(exe_payload), 160'd0);
    chk("mrst_cnt", 160'(stall_cnt), 160'd0);
    chk("mrst_ready", 160'(id_ready), 160'd1);

    // counter saturation over a 20-cycle stall
    drive(0, 1, 32'h40, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 32'h0, 0, 0);
      if (i == 14) chk("sat_cnt14", 160'(stall_cnt), 160'd14);
    end
    chk("sat_cnt", 160'(stall_cnt), 160'hF);
    chk("sat_pc_stable", 160'(exe_payload), 160'(mk(32'h40)));
    drive(0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 1, 0);
    chk("sat_cnt_hold", 160'(stall_cnt), 160'hF);
    chk("sat_drained", 160'(exe_valid), 160'd0);

    chk("sb_empty", 160'(sb.size()), 160'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
